// File: rtl/pa_ifu_ibuf_ctrl_pkg.sv
// Shared sizing constants and halfword-count helpers for the IFU instruction buffer.
// The entry array and the pointer controller both size themselves from these values.
package pa_ifu_ibuf_ctrl_pkg;

  localparam int IBUF_ENTRY_NUM = 8;
  localparam int IBUF_PTR_W     = $clog2(IBUF_ENTRY_NUM);
  localparam int IBUF_CNT_W     = IBUF_PTR_W + 1;

  // Encoding of fetch_hw_num / pop_hw_num; only ONE and TWO are legal when valid.
  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_ONE  = 2'd1,
    HW_TWO  = 2'd2,
    HW_ILL  = 2'd3
  } hw_num_e;

  // True when a request asks for both halfword lanes.
  function automatic logic is_two(input logic [1:0] hw_num);
    return hw_num == HW_TWO;
  endfunction

endpackage

// File: rtl/pa_ifu_ibuf_ctrl_if.sv
// Handshake and strobe bundle between fetch/decode and the ibuf pointer controller.
// The master side drives fetch/pop requests and flush; the slave side is the controller.
interface pa_ifu_ibuf_ctrl_if #(
  parameter int ENTRY_NUM = pa_ifu_ibuf_ctrl_pkg::IBUF_ENTRY_NUM,
  parameter int PTR_W     = pa_ifu_ibuf_ctrl_pkg::IBUF_PTR_W,
  parameter int CNT_W     = pa_ifu_ibuf_ctrl_pkg::IBUF_CNT_W
);

  logic                 ibuf_flush_en;
  logic                 fetch_vld;
  logic [1:0]           fetch_hw_num;
  logic                 ibuf_fetch_rdy;
  logic                 pop_vld;
  logic [1:0]           pop_hw_num;
  logic [ENTRY_NUM-1:0] ibuf_entry_create_en;
  logic [ENTRY_NUM-1:0] ibuf_entry_create_data_en;
  logic [ENTRY_NUM-1:0] ibuf_entry_create_sel;
  logic [ENTRY_NUM-1:0] ibuf_entry_retire_en;
  logic [PTR_W-1:0]     ibuf_rptr;
  logic [PTR_W-1:0]     ibuf_wptr;
  logic [CNT_W-1:0]     ibuf_cnt;
  logic                 ibuf_empty;
  logic [1:0]           ibuf_hw_avail;

  modport master (
    output ibuf_flush_en, fetch_vld, fetch_hw_num, pop_vld, pop_hw_num,
    input  ibuf_fetch_rdy, ibuf_entry_create_en, ibuf_entry_create_data_en,
           ibuf_entry_create_sel, ibuf_entry_retire_en, ibuf_rptr, ibuf_wptr,
           ibuf_cnt, ibuf_empty, ibuf_hw_avail
  );

  modport slave (
    input  ibuf_flush_en, fetch_vld, fetch_hw_num, pop_vld, pop_hw_num,
    output ibuf_fetch_rdy, ibuf_entry_create_en, ibuf_entry_create_data_en,
           ibuf_entry_create_sel, ibuf_entry_retire_en, ibuf_rptr, ibuf_wptr,
           ibuf_cnt, ibuf_empty, ibuf_hw_avail
  );

endinterface

// File: rtl/pa_ifu_ibuf_ptr_dec.sv
// Pointer decoder: marks entry ptr (enable0) and entry ptr+1 (enable1) in a one-hot/two-hot
// vector. ptr+1 wraps naturally at PTR_W bits, matching the circular entry array.
module pa_ifu_ibuf_ptr_dec #(
  parameter int ENTRY_NUM = pa_ifu_ibuf_ctrl_pkg::IBUF_ENTRY_NUM,
  parameter int PTR_W     = pa_ifu_ibuf_ctrl_pkg::IBUF_PTR_W
) (
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 enable0,
  input  logic                 enable1,
  output logic [ENTRY_NUM-1:0] vec
);

  logic [PTR_W-1:0] ptr_p1;

  assign ptr_p1 = ptr + PTR_W'(1);

  // Set the strobe bits for the slot at ptr and, when requested, the following slot.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned
    // (that would infer a latch); use blocking '=' inside combinational blocks.
    vec = '0;
    if (enable0) vec[ptr]    = 1'b1;
    if (enable1) vec[ptr_p1] = 1'b1;
  end

endmodule

// File: rtl/pa_ifu_ibuf_ctrl.sv
// Pointer/occupancy controller for the IFU halfword instruction buffer.
// Holds rptr/wptr/cnt, qualifies fetch pushes and decode pops, and drives the
// per-entry create/retire strobes plus the halfword-lane select.
module pa_ifu_ibuf_ctrl
  import pa_ifu_ibuf_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM = pa_ifu_ibuf_ctrl_pkg::IBUF_ENTRY_NUM,
  parameter int PTR_W     = pa_ifu_ibuf_ctrl_pkg::IBUF_PTR_W,
  parameter int CNT_W     = pa_ifu_ibuf_ctrl_pkg::IBUF_CNT_W
) (
  input logic                 ibuf_cpuclk,
  input logic                 cpurst_b,
  pa_ifu_ibuf_ctrl_if.slave   bus
);

  logic [PTR_W-1:0]     rptr;
  logic [PTR_W-1:0]     wptr;
  logic [CNT_W-1:0]     cnt;

  logic                 fetch_rdy;
  logic                 push;
  logic                 push_two;
  logic                 pop_any;
  logic                 pop_two;
  logic [1:0]           push_n;
  logic [1:0]           pop_n;
  logic [PTR_W-1:0]     wptr_p1;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [ENTRY_NUM-1:0] create_en;
  logic [ENTRY_NUM-1:0] retire_en;
  logic [ENTRY_NUM-1:0] create_sel;

  // Ready only with at least two free slots, so a 2-halfword offer always fits; this
  // deliberately refuses even a 1-halfword offer when a single slot is free.
  assign fetch_rdy = (cnt <= CNT_W'(ENTRY_NUM - 2));

  // Flush overrides both sides: no push, no pop in the redirect cycle.
  assign push     = bus.fetch_vld & fetch_rdy & ~bus.ibuf_flush_en;
  assign push_two = push & is_two(bus.fetch_hw_num);

  // Pop count is clamped to the current occupancy; same-cycle pushes are not bypassed.
  assign pop_any  = bus.pop_vld & ~bus.ibuf_flush_en & (cnt != '0);
  assign pop_two  = pop_any & is_two(bus.pop_hw_num) & (cnt >= CNT_W'(2));

  assign push_n   = push_two ? 2'd2 : {1'b0, push};
  assign pop_n    = pop_two  ? 2'd2 : {1'b0, pop_any};
  assign cnt_nxt  = cnt + CNT_W'(push_n) - CNT_W'(pop_n);
  assign wptr_p1  = wptr + PTR_W'(1);

  pa_ifu_ibuf_ptr_dec #(
    .ENTRY_NUM (ENTRY_NUM),
    .PTR_W     (PTR_W)
  ) u_create_dec (
    .ptr     (wptr),
    .enable0 (push),
    .enable1 (push_two),
    .vec     (create_en)
  );

  pa_ifu_ibuf_ptr_dec #(
    .ENTRY_NUM (ENTRY_NUM),
    .PTR_W     (PTR_W)
  ) u_retire_dec (
    .ptr     (rptr),
    .enable0 (pop_any),
    .enable1 (pop_two),
    .vec     (retire_en)
  );

  // The second created entry takes the fetch upper halfword; all others read lane 0.
  always_comb begin
    create_sel = '0;
    if (push_two) create_sel[wptr_p1] = 1'b1;
  end

  // Pointer and occupancy state; flush returns to the empty, reset-equivalent state.
  always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    if (!cpurst_b) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (bus.ibuf_flush_en) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      rptr <= rptr + PTR_W'(pop_n);
      wptr <= wptr + PTR_W'(push_n);
      cnt  <= cnt_nxt;
    end
  end

  assign bus.ibuf_fetch_rdy            = fetch_rdy;
  assign bus.ibuf_entry_create_en      = create_en;
  assign bus.ibuf_entry_create_data_en = create_en;
  assign bus.ibuf_entry_create_sel     = create_sel;
  assign bus.ibuf_entry_retire_en      = retire_en;
  assign bus.ibuf_rptr                 = rptr;
  assign bus.ibuf_wptr                 = wptr;
  assign bus.ibuf_cnt                  = cnt;
  assign bus.ibuf_empty                = (cnt == '0);
  assign bus.ibuf_hw_avail             = (cnt >= CNT_W'(2)) ? 2'd2 : cnt[1:0];

  // Protocol checks on the requesters: no pop from an empty buffer, no 0/3 halfword counts.
  a_pop_nonempty : assert property (@(posedge ibuf_cpuclk) disable iff (!cpurst_b)
    bus.pop_vld |-> (cnt != '0));
  a_fetch_hw_legal : assert property (@(posedge ibuf_cpuclk) disable iff (!cpurst_b)
    bus.fetch_vld |-> (bus.fetch_hw_num == HW_ONE || bus.fetch_hw_num == HW_TWO));
  a_pop_hw_legal : assert property (@(posedge ibuf_cpuclk) disable iff (!cpurst_b)
    bus.pop_vld |-> (bus.pop_hw_num == HW_ONE || bus.pop_hw_num == HW_TWO));

endmodule

// File: tb/tb_pa_ifu_ibuf_ctrl.sv
// Self-checking bench for pa_ifu_ibuf_ctrl: directed scenarios with literal expectations,
// a random push/pop/flush run, and an occupancy-level model compared every cycle.
module tb_pa_ifu_ibuf_ctrl;
  import pa_ifu_ibuf_ctrl_pkg::*;

  localparam int N = IBUF_ENTRY_NUM;

  logic ibuf_cpuclk = 1'b0;
  logic cpurst_b    = 1'b0;

  pa_ifu_ibuf_ctrl_if bus ();

  pa_ifu_ibuf_ctrl dut (
    .ibuf_cpuclk (ibuf_cpuclk),
    .cpurst_b    (cpurst_b),
    .bus         (bus)
  );

  always #5 ibuf_cpuclk = ~ibuf_cpuclk;

  int total = 0;
  int bad   = 0;

  // Model state: oldest slot, next free slot, occupancy (plain integers, mod N).
  int m_rptr = 0;
  int m_wptr = 0;
  int m_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Halfwords the buffer accepts this cycle: only with two or more free slots.
  function automatic int exp_push_n();
    if (bus.ibuf_flush_en || !bus.fetch_vld || (N - m_cnt) < 2) return 0;
    return int'(bus.fetch_hw_num);
  endfunction

  // Halfwords retired this cycle: request clamped to what is held.
  function automatic int exp_pop_n();
    int req;
    if (bus.ibuf_flush_en || !bus.pop_vld) return 0;
    req = int'(bus.pop_hw_num);
    return (req < m_cnt) ? req : m_cnt;
  endfunction

  // Bit set for each of n consecutive circular slots starting at base.
  function automatic logic [31:0] slots(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[(base + k) % N] = 1'b1;
    return v;
  endfunction

  // Model advances at each clock edge; async reset empties it.
  always @(posedge ibuf_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      m_rptr <= 0;
      m_wptr <= 0;
      m_cnt  <= 0;
    end else if (bus.ibuf_flush_en) begin
      m_rptr <= 0;
      m_wptr <= 0;
      m_cnt  <= 0;
    end else begin
      m_rptr <= (m_rptr + exp_pop_n()) % N;
      m_wptr <= (m_wptr + exp_push_n()) % N;
      m_cnt  <= m_cnt + exp_push_n() - exp_pop_n();
    end
  end

  // Every out-of-reset cycle, compare all outputs against the model mid-period.
  always @(negedge ibuf_cpuclk) begin
    if (cpurst_b) begin
      check("cmp_cnt",      32'(bus.ibuf_cnt),  32'(m_cnt));
      check("cmp_rptr",     32'(bus.ibuf_rptr), 32'(m_rptr));
      check("cmp_wptr",     32'(bus.ibuf_wptr), 32'(m_wptr));
      check("cmp_empty",    32'(bus.ibuf_empty), (m_cnt == 0) ? 32'd1 : 32'd0);
      check("cmp_rdy",      32'(bus.ibuf_fetch_rdy), (N - m_cnt >= 2) ? 32'd1 : 32'd0);
      check("cmp_avail",    32'(bus.ibuf_hw_avail), (m_cnt > 2) ? 32'd2 : 32'(m_cnt));
      check("cmp_create",   32'(bus.ibuf_entry_create_en), slots(m_wptr, exp_push_n()));
      check("cmp_data_en",  32'(bus.ibuf_entry_create_data_en), slots(m_wptr, exp_push_n()));
      check("cmp_sel",      32'(bus.ibuf_entry_create_sel),
            (exp_push_n() == 2) ? slots(m_wptr + 1, 1) : 32'd0);
      check("cmp_retire",   32'(bus.ibuf_entry_retire_en), slots(m_rptr, exp_pop_n()));
    end
  end

  // Drive one cycle of inputs just after the edge, then wait to the sampling point.
  task automatic cyc(input logic fv, input logic [1:0] fh, input logic pv,
                     input logic [1:0] ph, input logic fl);
    @(posedge ibuf_cpuclk);
    #1;
    bus.fetch_vld     = fv;
    bus.fetch_hw_num  = fh;
    bus.pop_vld       = pv;
    bus.pop_hw_num    = ph;
    bus.ibuf_flush_en = fl;
    @(negedge ibuf_cpuclk);
  endtask

  initial begin
    bus.fetch_vld     = 1'b0;
    bus.fetch_hw_num  = 2'd1;
    bus.pop_vld       = 1'b0;
    bus.pop_hw_num    = 2'd1;
    bus.ibuf_flush_en = 1'b0;

    // Reset state, sampled while reset is held.
    @(negedge ibuf_cpuclk);
    check("rst_cnt",    32'(bus.ibuf_cnt), 32'd0);
    check("rst_empty",  32'(bus.ibuf_empty), 32'd1);
    check("rst_rdy",    32'(bus.ibuf_fetch_rdy), 32'd1);
    check("rst_avail",  32'(bus.ibuf_hw_avail), 32'd0);
    check("rst_create", 32'(bus.ibuf_entry_create_en), 32'd0);
    check("rst_retire", 32'(bus.ibuf_entry_retire_en), 32'd0);
    check("rst_sel",    32'(bus.ibuf_entry_create_sel), 32'd0);
    check("rst_ptrs",   32'({bus.ibuf_rptr, bus.ibuf_wptr}), 32'd0);
    #2 cpurst_b = 1'b1;

    // Fill with four 2-halfword pushes; wptr wraps back to 0.
    cyc(1, 2, 0, 1, 0);
    check("fill0_create", 32'(bus.ibuf_entry_create_en), 32'h03);
    check("fill0_sel",    32'(bus.ibuf_entry_create_sel), 32'h02);
    cyc(1, 2, 0, 1, 0);
    cyc(1, 2, 0, 1, 0);
    cyc(1, 2, 0, 1, 0);
    check("fill3_create", 32'(bus.ibuf_entry_create_en), 32'hC0);
    check("fill3_sel",    32'(bus.ibuf_entry_create_sel), 32'h80);
    check("fill3_cnt",    32'(bus.ibuf_cnt), 32'd6);
    // Fifth offer is dropped.
    cyc(1, 2, 0, 1, 0);
    check("full_cnt",     32'(bus.ibuf_cnt), 32'd8);
    check("full_model",   32'(m_cnt), 32'd8);
    check("full_wptr",    32'(bus.ibuf_wptr), 32'd0);
    check("full_rdy",     32'(bus.ibuf_fetch_rdy), 32'd0);
    check("full_create",  32'(bus.ibuf_entry_create_en), 32'd0);
    check("full_avail",   32'(bus.ibuf_hw_avail), 32'd2);

    // Pop 2 while full with a fetch offer: retire only.
    cyc(1, 2, 1, 2, 0);
    check("popfull_retire", 32'(bus.ibuf_entry_retire_en), 32'h03);
    check("popfull_create", 32'(bus.ibuf_entry_create_en), 32'd0);
    cyc(0, 1, 1, 2, 0);
    check("pop_cnt6",     32'(bus.ibuf_cnt), 32'd6);
    check("pop_rptr2",    32'(bus.ibuf_rptr), 32'd2);
    check("pop_retire",   32'(bus.ibuf_entry_retire_en), 32'h0C);
    cyc(0, 1, 1, 2, 0);
    check("pop_retire2",  32'(bus.ibuf_entry_retire_en), 32'h30);
    cyc(1, 2, 1, 1, 0);
    check("mix_create",   32'(bus.ibuf_entry_create_en), 32'h03);
    check("mix_retire",   32'(bus.ibuf_entry_retire_en), 32'h40);

    // rptr=7, cnt=3, wptr=2: both sides wrap in one cycle.
    cyc(1, 2, 1, 2, 0);
    check("wrap_state",   32'({bus.ibuf_rptr, bus.ibuf_wptr, bus.ibuf_cnt}),
          32'({3'd7, 3'd2, 4'd3}));
    check("wrap_retire",  32'(bus.ibuf_entry_retire_en), 32'h81);
    check("wrap_create",  32'(bus.ibuf_entry_create_en), 32'h0C);
    check("wrap_data_en", 32'(bus.ibuf_entry_create_data_en), 32'h0C);
    check("wrap_sel",     32'(bus.ibuf_entry_create_sel), 32'h08);
    cyc(1, 2, 0, 1, 0);
    check("wrap_next",    32'({bus.ibuf_rptr, bus.ibuf_wptr, bus.ibuf_cnt}),
          32'({3'd1, 3'd4, 4'd3}));
    cyc(1, 2, 0, 1, 0);
    // cnt=7: even a 1-halfword offer is refused.
    cyc(1, 1, 0, 1, 0);
    check("cnt7_cnt",     32'(bus.ibuf_cnt), 32'd7);
    check("cnt7_rdy",     32'(bus.ibuf_fetch_rdy), 32'd0);
    check("cnt7_create",  32'(bus.ibuf_entry_create_en), 32'd0);
    cyc(0, 1, 1, 2, 0);

    // cnt=5: pop + push + flush together -> no strobes, then empty.
    cyc(1, 2, 1, 2, 1);
    check("flush_cnt5",   32'(bus.ibuf_cnt), 32'd5);
    check("flush_create", 32'(bus.ibuf_entry_create_en), 32'd0);
    check("flush_retire", 32'(bus.ibuf_entry_retire_en), 32'd0);
    cyc(0, 1, 0, 1, 0);
    check("post_flush",   32'({bus.ibuf_rptr, bus.ibuf_wptr, bus.ibuf_cnt}), 32'd0);
    check("post_empty",   32'(bus.ibuf_empty), 32'd1);

    // cnt=1 with a 2-halfword pop: clamped to one retire.
    cyc(1, 1, 0, 1, 0);
    check("one_create",   32'(bus.ibuf_entry_create_en), 32'h01);
    check("one_sel",      32'(bus.ibuf_entry_create_sel), 32'h00);
    cyc(0, 1, 1, 2, 0);
    check("clamp_avail",  32'(bus.ibuf_hw_avail), 32'd1);
    check("clamp_retire", 32'(bus.ibuf_entry_retire_en), 32'h01);
    cyc(0, 1, 0, 1, 0);
    check("clamp_cnt",    32'(bus.ibuf_cnt), 32'd0);

    // Random traffic; pops only while the model holds data; one async reset midway.
    for (int i = 0; i < 400; i++) begin
      @(posedge ibuf_cpuclk);
      if (i == 200) begin
        #2;
        bus.fetch_vld     = 1'b0;
        bus.pop_vld       = 1'b0;
        bus.ibuf_flush_en = 1'b0;
        cpurst_b          = 1'b0;
        #2;
        check("async_rst_cnt",  32'(bus.ibuf_cnt), 32'd0);
        check("async_rst_ptrs", 32'({bus.ibuf_rptr, bus.ibuf_wptr}), 32'd0);
        #2 cpurst_b = 1'b1;
      end else begin
        #1;
        bus.fetch_vld     = 1'($urandom_range(0, 1));
        bus.fetch_hw_num  = 2'($urandom_range(1, 2));
        bus.pop_vld       = (m_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.pop_hw_num    = 2'($urandom_range(1, 2));
        bus.ibuf_flush_en = ($urandom_range(0, 24) == 0);
      end
    end

    @(posedge ibuf_cpuclk);
    #1;
    bus.fetch_vld     = 1'b0;
    bus.pop_vld       = 1'b0;
    bus.ibuf_flush_en = 1'b0;
    @(negedge ibuf_cpuclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
